// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-side access stage: fetch/load/store handshake, lane alignment, IR
// Stalls the control FSM until an access completes; flags misaligned accesses and bus timeouts.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_INSTR    = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adr_src_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] wdata_in_i,
  input  logic [2:0]  funct3_i,
  input  logic        ir_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  output logic        stall_o,
  output logic [31:0] instr_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_fetch_q, is_fetch_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        strobe, is_fetch, is_store, sz_byte, sz_half, misal;
  logic [31:0] addr;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_data;

  assign strobe   = ir_write_i | mem_read_i | mem_write_i;
  assign addr     = adr_src_i ? alu_out_i : pc_i;
  assign is_fetch = ir_write_i;
  assign is_store = !ir_write_i && mem_write_i;
  // Fetches are always word-sized; reserved funct3 encodings fall through to word.
  assign sz_byte  = !is_fetch && (funct3_i[1:0] == 2'b00);
  assign sz_half  = !is_fetch && (funct3_i[1:0] == 2'b01);
  assign misal    = sz_byte ? 1'b0 : (sz_half ? addr[0] : (addr[1:0] != 2'b00));

  always_comb begin
    lane_b = 8'h00;
    case (off_q)
      2'd0: lane_b = bus_rdata_i[7:0];
      2'd1: lane_b = bus_rdata_i[15:8];
      2'd2: lane_b = bus_rdata_i[23:16];
      default: lane_b = bus_rdata_i[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ext_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  ext_data = {24'h0, lane_b};
      3'b001:  ext_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  ext_data = {16'h0, lane_h};
      default: ext_data = bus_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_wdata_d  = bus_wdata_q;
    instr_d      = instr_q;
    load_data_d  = load_data_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    cnt_d        = cnt_q;
    is_fetch_d   = is_fetch_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    stall_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          if (misal) begin
            misaligned_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            stall_o     = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wstrb_d = 4'b0000;
            bus_wdata_d = 32'h0;
            if (is_store) begin
              if (sz_byte) begin
                bus_wstrb_d = 4'b0001 << addr[1:0];
                bus_wdata_d = {4{wdata_in_i[7:0]}};
              end else if (sz_half) begin
                bus_wstrb_d = 4'b0011 << {addr[1], 1'b0};
                bus_wdata_d = {2{wdata_in_i[15:0]}};
              end else begin
                bus_wstrb_d = 4'b1111;
                bus_wdata_d = wdata_in_i;
              end
            end
            is_fetch_d = is_fetch;
            is_store_d = is_store;
            funct3_d   = funct3_i;
            off_d      = addr[1:0];
            cnt_d      = 8'd0;
            state_d    = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (bus_ack_i) begin
          if (is_fetch_q) begin
            instr_d = bus_rdata_i;
          end else if (!is_store_q) begin
            load_data_d = ext_data;
          end
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'h0;
      bus_wstrb_q  <= 4'h0;
      bus_wdata_q  <= 32'h0;
      instr_q      <= RESET_INSTR;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= 8'd0;
      is_fetch_q   <= 1'b0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_wdata_q  <= bus_wdata_d;
      instr_q      <= instr_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
      is_fetch_q   <= is_fetch_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign instr_o      = instr_q;
  assign load_data_o  = load_data_q;
  assign misaligned_o = misaligned_q;
  assign bus_err_o    = bus_err_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wstrb_o  = bus_wstrb_q;
  assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
// Reference model computes sizes, lanes and extensions arithmetically from the access rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adr_src = 1'b0;
  logic [31:0] pc = 32'h0, alu_out = 32'h0, wdata_in = 32'h0;
  logic [2:0]  funct3 = 3'b000;
  logic        ir_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic        stall, misaligned, bus_err, bus_req, bus_we;
  logic [31:0] instr, load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_instr = 32'h00000013;
  logic [31:0] exp_load  = 32'h0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i(clk), .rst_i(rst), .adr_src_i(adr_src), .pc_i(pc), .alu_out_i(alu_out),
    .wdata_in_i(wdata_in), .funct3_i(funct3), .ir_write_i(ir_write), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .stall_o(stall), .instr_o(instr), .load_data_o(load_data),
    .misaligned_o(misaligned), .bus_err_o(bus_err), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store
  function automatic int m_size(input int kind, input logic [2:0] f3);
    if (kind == 0) return 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    sh = (a % 4) * 8;
    case (f3)
      3'd0: begin v = (rd >> sh) & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4: v = (rd >> sh) & 32'hFF;
      3'd1: begin v = (rd >> sh) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd5: v = (rd >> sh) & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic drop_strobes();
    ir_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic access(input int kind, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int sz, nstall, nreq;
    bit mis;
    logic [31:0] ewstrb, ewdata;
    sz  = m_size(kind, f3);
    mis = (a % sz) != 0;
    ewstrb = (kind == 2) ? (((32'd1 << sz) - 1) << (a % 4)) : 32'd0;
    ewdata = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
             (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    adr_src = (kind != 0);
    pc      = (kind == 0) ? a : $urandom;
    alu_out = (kind == 0) ? $urandom : a;
    funct3 = f3; wdata_in = wd;
    ir_write  = (kind == 0);
    mem_read  = (kind == 1);
    mem_write = (kind == 2);
    #1;
    check("stall_strobe", {31'b0, stall}, {31'b0, !mis});
    @(negedge clk);
    if (mis) begin
      check("mis_req", {31'b0, bus_req}, 32'd0);
      check("mis_pulse", {31'b0, misaligned}, 32'd1);
      check("mis_stall", {31'b0, stall}, 32'd0);
      drop_strobes();
      @(negedge clk);
      check("mis_pulse_end", {31'b0, misaligned}, 32'd0);
      check("mis_instr", instr, exp_instr);
      check("mis_load", load_data, exp_load);
      return;
    end
    check("req_addr", bus_addr, a & 32'hFFFF_FFFC);
    check("req_we", {31'b0, bus_we}, {31'b0, kind == 2});
    check("req_wstrb", {28'b0, bus_wstrb}, ewstrb);
    if (kind == 2) check("req_wdata", bus_wdata, ewdata);
    nstall = 1; nreq = 0;
    for (int i = 1; i <= waits; i++) begin
      if (stall) nstall++;
      if (bus_req) nreq++;
      if (i == waits) begin bus_ack = 1'b1; bus_rdata = rd; end
      else bus_rdata = $urandom;
      @(negedge clk);
      bus_ack = 1'b0;
    end
    if (kind == 0) exp_instr = rd;
    if (kind == 1) exp_load = m_load(f3, a, rd);
    check("stall_cycles", nstall, waits + 1);
    check("req_cycles", nreq, waits);
    check("done_stall", {31'b0, stall}, 32'd0);
    check("done_req", {31'b0, bus_req}, 32'd0);
    check("done_err", {31'b0, bus_err}, 32'd0);
    check("instr", instr, exp_instr);
    check("load_data", load_data, exp_load);
    drop_strobes();
    @(negedge clk);
    check("idle_req", {31'b0, bus_req}, 32'd0);
  endtask

  initial begin
    int n;
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    repeat (2) @(negedge clk);
    check("rst_instr", instr, 32'h00000013);
    check("rst_req", {31'b0, bus_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_load", load_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(0, 32'h100, 3'd2, 32'h0, 32'h00500093, 3);
    check("fetch_instr", instr, 32'h00500093);
    access(1, 32'h203, 3'd0, 32'h0, 32'h80FFFFFF, 2);
    check("lb_val", load_data, 32'hFFFFFF80);
    access(1, 32'h203, 3'd4, 32'h0, 32'h80FFFFFF, 1);
    check("lbu_val", load_data, 32'h00000080);
    access(2, 32'h402, 3'd1, 32'h1234ABCD, 32'h0, 2);
    access(1, 32'h101, 3'd2, 32'h0, 32'h0, 1);

    for (int k = 0; k < 40; k++) begin
      access($urandom_range(0, 2), $urandom, f3_tab[$urandom_range(0, 7)],
             $urandom, $urandom, $urandom_range(1, 5));
    end

    // timeout: no ack ever arrives
    adr_src = 1'b0; pc = 32'h300; ir_write = 1'b1;
    @(negedge clk);
    n = 0;
    while (bus_req && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("to_busy_cycles", n, 255);
    check("to_err_pulse", {31'b0, bus_err}, 32'd1);
    check("to_stall", {31'b0, stall}, 32'd0);
    check("to_instr", instr, exp_instr);
    drop_strobes();
    @(negedge clk);
    check("to_err_end", {31'b0, bus_err}, 32'd0);

    // reset while BUSY, then a late ack
    adr_src = 1'b0; pc = 32'h500; ir_write = 1'b1;
    @(negedge clk);
    check("rb_req", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    drop_strobes();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_instr = 32'h00000013; exp_load = 32'h0;
    check("rb_req_drop", {31'b0, bus_req}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("rb_late_instr", instr, 32'h00000013);
    check("rb_late_req", {31'b0, bus_req}, 32'd0);
    check("rb_late_stall", {31'b0, stall}, 32'd0);
    access(0, 32'h504, 3'd2, 32'h0, 32'h00A00113, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
